// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and constants for the bit-serial operand
//                feeder: sequencer state encoding, default operand width
//                and the beat-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Default operand width in bits (legal range 1..32)
    localparam int DEFAULT_WIDTH = 4;

    // Sequencer states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Beat counter width: wide enough to hold 0..WIDTH
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_operand_feeder_piso_shift.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift
//  Description : Parallel-in serial-out shift register. Load takes priority
//                over shift; shifting moves data toward bit 0 with zero fill.
//                Bit 0 is presented on ser_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             ser_out
);

    logic [WIDTH-1:0] r_sh;

    // Load a new word or shift right by one with zero fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh <= '0;
        end else if (load) begin
            r_sh <= load_data;
        end else if (shift_en) begin
            r_sh <= r_sh >> 1;
        end
    end

    assign ser_out = r_sh[0];

endmodule : piso_shift
`default_nettype wire

// File: rtl/serial_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_operand_feeder
//  Description : Accepts an operand pair over valid/ready and streams it
//                LSB-first, one bit pair per accepted beat, with first/last
//                framing for a downstream bit-serial adder. A new pair may be
//                loaded on the last beat for zero-bubble back-to-back use.
//  Options     : SERIAL_SUB_EN - adds in_sub; when latched high, B is
//                inverted and cin_bit=1 on the first beat (A-B).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_operand_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_SUB_EN
    input  logic             in_sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_a,
    output logic             bit_b,
    output logic             cin_bit,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_first,
    output logic             bit_last,
    output logic             busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic          r_first;
    logic          r_last;

    logic          w_beat;
    logic          w_load;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_a0;
    logic          w_b0;

    assign w_beat    = r_valid & bit_ready;
    // In SHIFT a new pair is only taken on the final accepted beat
    assign in_ready  = (r_state == IDLE) | (r_last & bit_ready);
    assign w_load    = in_valid & in_ready;
    assign w_cnt_nxt = r_cnt + CW'(1);

    piso_shift #(.WIDTH(WIDTH)) u_sh_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .load_data (in_a),
        .shift_en  (w_beat),
        .ser_out   (w_a0)
    );

    piso_shift #(.WIDTH(WIDTH)) u_sh_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .load_data (in_b),
        .shift_en  (w_beat),
        .ser_out   (w_b0)
    );

    // Sequencer: state, beat counter and registered framing flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_first <= 1'b1;
                        r_last  <= (LAST_CNT == '0);
                    end
                end
                SHIFT: begin
                    if (bit_ready) begin
                        if (r_last) begin
                            if (in_valid) begin
                                // Back-to-back: restart at bit 0 without a bubble
                                r_cnt   <= '0;
                                r_first <= 1'b1;
                                r_last  <= (LAST_CNT == '0);
                            end else begin
                                r_state <= IDLE;
                                r_cnt   <= '0;
                                r_valid <= 1'b0;
                                r_first <= 1'b0;
                                r_last  <= 1'b0;
                            end
                        end else begin
                            r_cnt   <= w_cnt_nxt;
                            r_first <= 1'b0;
                            r_last  <= (w_cnt_nxt == LAST_CNT);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_first <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign bit_valid = r_valid;
    assign bit_first = r_first;
    assign bit_last  = r_last;
    assign busy      = (r_state == SHIFT);
    assign bit_a     = r_valid & w_a0;

`ifdef SERIAL_SUB_EN
    logic r_sub;

    // Subtract flag travels with the operand pair it was sampled with
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else if (w_load) begin
            r_sub <= in_sub;
        end else if (w_beat && r_last) begin
            r_sub <= 1'b0;
        end
    end

    assign bit_b   = r_valid & (w_b0 ^ r_sub);
    assign cin_bit = r_sub & r_first;
`else
    assign bit_b   = r_valid & w_b0;
    assign cin_bit = 1'b0;
`endif

endmodule : serial_operand_feeder
`default_nettype wire

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
Upstream stage of the bit-serial adder datapath. It accepts a pair of parallel operands through a valid/ready handshake and presents them LSB-first, one bit pair per accepted beat. Each beat carries first/last framing so the downstream serial adder knows when to clear its carry flop and when the result is complete. It replaces the free-running, unframed operand shift registers with a stallable, reset-safe sequencer.

Parameters:
WIDTH, 4, operand width in bits; legal range 1..32.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
in_valid  in  1  operand pair is valid.
in_ready  out  1  block can accept a pair this cycle.
bit_a  out  1  current bit of A.
bit_b  out  1  current bit of B, after the optional inversion.
cin_bit  out  1  carry-in for the downstream carry flop; meaningful only when bit_first=1.
bit_valid  out  1  bit pair is valid.
bit_ready  in  1  downstream accepts the bit pair this cycle.
bit_first  out  1  current beat is bit 0; downstream loads its carry from cin_bit.
bit_last  out  1  current beat is bit WIDTH-1.
busy  out  1  an operation is in progress (state SHIFT).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; shift registers, count and sub flag cleared.
  - Outputs: bit_valid=0, bit_a=0, bit_b=0, cin_bit=0, bit_first=0, bit_last=0, busy=0, in_ready=1 once rst_n is released.
- States:
  - IDLE: in_ready=1, bit_valid=0. On in_valid&&in_ready, load a_sh=in_a, b_sh=in_b, cnt=0, then go to SHIFT.
  - SHIFT: bit_valid=1, busy=1. Outputs:
    - bit_a=a_sh[0], bit_b=b_sh[0]
    - bit_first=(cnt==0), bit_last=(cnt==WIDTH-1)
- Beat acceptance: beat = bit_valid&&bit_ready. On a beat, shift a_sh and b_sh right by one (zero fill) and increment cnt.
- End of operation: on a beat with bit_last=1, return to IDLE. Exception: if in_valid is also high, reload directly and stay in SHIFT (zero-bubble back-to-back).
- in_ready in SHIFT: equals bit_last&&bit_ready. This is a combinational path from bit_ready, which is intended. in_ready=0 in SHIFT otherwise.
- Stall: while bit_ready=0 in SHIFT, all outputs and state are held unchanged.
- Latency: first bit_valid appears one cycle after operand acceptance. With bit_ready tied high, an operation takes exactly WIDTH beats.
- WIDTH=1: bit_first and bit_last are both 1 on the single beat.
- cnt width is $clog2(WIDTH+1). cnt never exceeds WIDTH-1.
- in_a/in_b changing while busy has no effect.
- Reset mid-operation aborts immediately, with no final beat. The next operation restarts at bit 0.

Optional Feature:
SERIAL_SUB_EN.
- Defined:
  - Adds input port in_sub (1 bit), sampled with the operands.
  - When sub is latched as 1: bit_b = b_sh[0] ^ 1 and cin_bit=1 on the first beat, so the downstream adder computes A-B in two's complement.
  - When sub is latched as 0: identical to the undefined build.
- Undefined: port in_sub is absent and cin_bit is constant 0.

Decomposition:
- Shared package serial_pkg:
  - state enum (IDLE, SHIFT)
  - default WIDTH constant
  - function computing the count width
- One sub-module, piso_shift: a parallel-in serial-out shift register with load, shift enable and asynchronous active-low reset. It is instantiated twice, for A and B. The FSM and counter stay in serial_operand_feeder.

Test Plan:
- Basic operation, WIDTH=4, in_a=1001, in_b=0111, bit_ready=1:
  - four beats; bit_a=1,0,0,1 and bit_b=1,1,1,0
  - bit_first on beat 1 only, bit_last on beat 4 only
  - in_ready=0 on beats 1-3 and 1 in IDLE afterwards.
- Stall: same operands, bit_ready=0 for 3 cycles during beat 2 -> bit_a=0, bit_b=1 and cnt held; resumes with the beat-3 values (0,1).
- Back-to-back: second pair 0011/0101 presented with in_valid held -> accepted on the beat-4 cycle of the first pair; next cycle shows bit_first=1, bit_a=1, bit_b=1, with no idle cycle between operations.
- Reset mid-operation: rst_n low after beat 2 -> bit_valid=0, busy=0 asynchronously; a new pair 1111/0001 then produces a full 4-beat sequence starting with bit_first=1.
- WIDTH=1 and WIDTH=8 (in_a=8'hA5) -> a single beat with first=last=1; for WIDTH=8, bit_a=1,0,1,0,0,1,0,1 with last on beat 8.
- SERIAL_SUB_EN defined, 1001 minus 0111 (in_sub=1) -> bit_b=0,0,0,1 and cin_bit=1 on beat 1 only; the downstream model's sum equals 0010.
